// File: rtl/fp32_pkg.sv
// Shared constants, FSM encodings and operand classification for the sequential
// single-precision multiplier.
package fp32_pkg;

  localparam int          BIAS       = 127;
  localparam logic [31:0] QNAN       = 32'h7FC00000;
  localparam logic [31:0] POS_INF    = 32'h7F800000;
  localparam logic [9:0]  EXP_MAX    = 10'd255;
  localparam int          MUL_CYCLES = 24;
  localparam logic [4:0]  MUL_LAST   = 5'(MUL_CYCLES - 1);
  localparam logic [9:0]  NEG_BIAS   = 10'(-BIAS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} op_class_t;

  // Denormals (exp == 0) are flushed and therefore classify as zero.
  function automatic op_class_t classify(input logic [31:0] x);
    if (x[30:23] == 8'h00) return CLS_ZERO;
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'h0) ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/adder_10bit.sv
// 10-bit ripple-carry adder cell; results wrap modulo 2^10 (two's complement).
module adder_10bit (
  input  logic [9:0] a_i,
  input  logic [9:0] b_i,
  input  logic       cin_i,
  output logic [9:0] sum_o
);
  logic [10:0] c;

  assign c[0] = cin_i;
  for (genvar i = 0; i < 10; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
endmodule

// File: rtl/adder_24bit.sv
// 24-bit ripple-carry adder cell.
module adder_24bit (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic        cin_i,
  output logic [23:0] sum_o,
  output logic        cout_o
);
  logic [24:0] c;

  assign c[0] = cin_i;
  for (genvar i = 0; i < 24; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[24];
endmodule

// File: rtl/mant_mul_seq.sv
// 24x24 shift-add mantissa multiplier: one multiplier bit per step, product
// complete after MUL_CYCLES steps.
module mant_mul_seq import fp32_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [23:0] mcand_i,
  input  logic [23:0] mplier_i,
  output logic [47:0] product_o,
  output logic        last_o
);
  logic [23:0] m_q, l_q;
  logic [24:0] h_q, h_add;
  logic [4:0]  cnt_q;
  logic [23:0] sum;
  logic        cout;

  adder_24bit u_add (
    .a_i   (h_q[23:0]),
    .b_i   (m_q),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(cout)
  );

  assign h_add = l_q[0] ? {cout, sum} : h_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q   <= '0;
      l_q   <= '0;
      h_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      m_q   <= mcand_i;
      l_q   <= mplier_i;
      h_q   <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      h_q   <= {1'b0, h_add[24:1]};
      l_q   <= {h_add[0], l_q[23:1]};
      cnt_q <= cnt_q + 5'd1;
    end
  end

  assign product_o = {h_q[23:0], l_q};
  assign last_o    = (cnt_q == MUL_LAST);
endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential IEEE-754 single multiplier, round-toward-zero, denormals flushed.
// Fixed 25-cycle latency from accept to result for every operand class.
//   state | meaning
//   IDLE  | waiting for start; captures operands and classes
//   MUL   | 24 shift-add mantissa steps
//   NORM  | exponent/normalise, register result and flags, pulse done
module fp32_mul_seq import fp32_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        inv
);
  logic [1:0]  state_q, state_d;
  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  op_class_t   cls_a_q, cls_b_q;
  logic        accept, mul_last;
  logic [47:0] prod;
  logic [22:0] unused_prod_lo;
  logic [9:0]  esum, eexp;
  logic [22:0] mant;
  logic [31:0] res_d;
  logic        ovf_d, unf_d, inv_d;
  logic        any_nan, any_inf, any_zero;

  assign accept = (state_q == IDLE) && start;
  assign busy   = (state_q != IDLE);

  mant_mul_seq u_mul (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (accept),
    .step_i   (state_q == MUL),
    .mcand_i  ({1'b1, a[22:0]}),
    .mplier_i ({1'b1, b[22:0]}),
    .product_o(prod),
    .last_o   (mul_last)
  );

  // Second adder folds in -BIAS and the normalisation increment via carry-in.
  adder_10bit u_eadd (
    .a_i  ({2'b00, ea_q}),
    .b_i  ({2'b00, eb_q}),
    .cin_i(1'b0),
    .sum_o(esum)
  );

  adder_10bit u_ebias (
    .a_i  (esum),
    .b_i  (NEG_BIAS),
    .cin_i(prod[47]),
    .sum_o(eexp)
  );

  // Low product bits are discarded by truncation.
  assign unused_prod_lo = prod[22:0];
  assign mant = prod[47] ? prod[46:24] : prod[45:23];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (mul_last) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    any_nan  = (cls_a_q == CLS_NAN)  || (cls_b_q == CLS_NAN);
    any_inf  = (cls_a_q == CLS_INF)  || (cls_b_q == CLS_INF);
    any_zero = (cls_a_q == CLS_ZERO) || (cls_b_q == CLS_ZERO);
    res_d = {sign_q, 31'h0};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (any_nan || (any_inf && any_zero)) begin
      res_d = QNAN;
      inv_d = 1'b1;
    end else if (any_inf) begin
      res_d = {sign_q, POS_INF[30:0]};
    end else if (any_zero) begin
      res_d = {sign_q, 31'h0};
    end else if ($signed(eexp) >= $signed(EXP_MAX)) begin
      res_d = {sign_q, POS_INF[30:0]};
      ovf_d = 1'b1;
    end else if ($signed(eexp) <= $signed(10'd0)) begin
      res_d = {sign_q, 31'h0};
      unf_d = 1'b1;
    end else begin
      res_d = {sign_q, eexp[7:0], mant};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      cls_a_q <= CLS_ZERO;
      cls_b_q <= CLS_ZERO;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      inv     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (accept) begin
        sign_q  <= a[31] ^ b[31];
        ea_q    <= a[30:23];
        eb_q    <= b[30:23];
        cls_a_q <= classify(a);
        cls_b_q <= classify(b);
      end
      if (state_q == NORM) begin
        result <= res_d;
        ovf    <= ovf_d;
        unf    <= unf_d;
        inv    <= inv_d;
        done   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: vector table through a scoreboard,
// plus handshake and mid-operation reset sequences.
module tb_fp32_mul_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done, ovf, unf, inv;
  logic [31:0] result;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf, unf, inv;
  } exp_t;

  typedef struct packed {
    logic [31:0] a, b;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[20];
  int   errors = 0, checks = 0, done_cnt = 0;
  logic prev_done = 1'b0;

  fp32_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .ovf(ovf), .unf(unf), .inv(inv)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, vb, vr, input logic o, u, i);
    vec_t v;
    v.a = va; v.b = vb;
    v.e.res = vr; v.e.ovf = o; v.e.unf = u; v.e.inv = i;
    return v;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (prev_done) check1("done_pulse_width", done, 1'b0);
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        e = sb_q.pop_front();
        check32("result", result, e.res);
        check1("ovf", ovf, e.ovf);
        check1("unf", unf, e.unf);
        check1("inv", inv, e.inv);
      end
    end
    prev_done = done;
  end

  // Waits for done, n is edges already elapsed since accept.
  task automatic wait_done(input string name, input int n_start);
    int  n;
    bit  seen;
    n = n_start;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d edges expected 25", name, n);
      sb_q.delete();
    end else begin
      check32({name, "_latency"}, 32'(n), 32'd25);
      check1({name, "_busy_at_done"}, busy, 1'b0);
    end
  endtask

  task automatic run_op(input vec_t v);
    a = v.a;
    b = v.b;
    start = 1'b1;
    sb_q.push_back(v.e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check1("busy_after_accept", busy, 1'b1);
    wait_done("op", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int d0;
    vecs[0]  = mk(32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 0);
    vecs[1]  = mk(32'hC0400000, 32'h3F000000, 32'hBFC00000, 0, 0, 0);
    vecs[2]  = mk(32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0);
    vecs[3]  = mk(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0);
    vecs[4]  = mk(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0);
    vecs[5]  = mk(32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1);
    vecs[6]  = mk(32'hFFC00001, 32'h3F800000, 32'h7FC00000, 0, 0, 1);
    vecs[7]  = mk(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0);
    vecs[8]  = mk(32'h7F800000, 32'hBF800000, 32'hFF800000, 0, 0, 0);
    vecs[9]  = mk(32'h80000000, 32'h40400000, 32'h80000000, 0, 0, 0);
    vecs[10] = mk(32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 0);
    vecs[11] = mk(32'h00000000, 32'hFF800000, 32'h7FC00000, 0, 0, 1);
    vecs[12] = mk(32'h3F800000, 32'h7F800001, 32'h7FC00000, 0, 0, 1);
    vecs[13] = mk(32'h40000000, 32'hC0000000, 32'hC0800000, 0, 0, 0);
    vecs[14] = mk(32'h5F800000, 32'h5F800000, 32'h7F800000, 1, 0, 0);
    vecs[15] = mk(32'h5F000000, 32'h5F800000, 32'h7F000000, 0, 0, 0);
    vecs[16] = mk(32'h5F400000, 32'h5F400000, 32'h7F100000, 0, 0, 0);
    vecs[17] = mk(32'h00800000, 32'h3F800000, 32'h00800000, 0, 0, 0);
    vecs[18] = mk(32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 0);
    vecs[19] = mk(32'h00C00000, 32'h3F400000, 32'h00900000, 0, 0, 0);

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check32("rst_result", result, 32'h0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_unf", unf, 1'b0);
    check1("rst_inv", inv, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: each new start lands in the cycle done is high.
    for (int i = 0; i < 20; i++) run_op(vecs[i]);

    // Second start during MUL is ignored.
    @(negedge clk);
    d0 = done_cnt;
    a = 32'h3FC00000; b = 32'h40000000; start = 1'b1;
    sb_q.push_back(vecs[0].e);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 32'h7F800000; b = 32'h00000000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check1("busy_during_ignored_start", busy, 1'b1);
    wait_done("ignored_start", 5);
    repeat (30) @(posedge clk);
    #1;
    check32("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of an operation.
    @(negedge clk);
    d0 = done_cnt;
    a = 32'h40000000; b = 32'h40000000; start = 1'b1;
    sb_q.push_back(vecs[13].e);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check1("midrst_busy", busy, 1'b0);
    check32("midrst_result", result, 32'h0);
    check1("midrst_done", done, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check32("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);
    run_op(vecs[7]);

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
